// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply controller for the Montgomery product engine.
// Owns the 4-word operand memory the engine reads and writes.
module mod_exp_ctrl #(
  parameter int unsigned ABITS      = 8,
  parameter int unsigned DBITS      = 256,
  parameter int unsigned LOG_BITLEN = 8,
  parameter int unsigned MP_COUNT   = 256,
  parameter int unsigned EBITS      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [EBITS-1:0]      exp,
  input  logic [8:0]            exp_len,
  input  logic [DBITS-1:0]      x_bar_init,
  input  logic [DBITS-1:0]      m_bar_init,
  output logic                  busy,
  output logic                  done,
  output logic [DBITS-1:0]      result,
  output logic                  mp_start,
  output logic [1:0]            mp_op_code,
  output logic [LOG_BITLEN:0]   mp_count,
  input  logic                  mp_stop,
  input  logic [ABITS-1:0]      mp_rd_addr,
  output logic [DBITS-1:0]      mp_rd_data,
  input  logic [ABITS-1:0]      mp_wr_addr,
  input  logic [DBITS-1:0]      mp_wr_data,
  input  logic                  mp_wr_en
);

  localparam int unsigned IdxW    = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam int unsigned CntW    = $clog2(MP_COUNT + 5);
  localparam logic [1:0]  OpXX    = 2'd0;
  localparam logic [1:0]  OpXM    = 2'd1;
  localparam logic [1:0]  OpX1    = 2'd2;
  localparam logic [CntW-1:0] DrainLast = CntW'(MP_COUNT + 3);

  typedef enum logic [3:0] {
    StDrain,
    StIdle,
    StLoad,
    StSqIssue,
    StSqWait,
    StMulIssue,
    StMulWait,
    StFinIssue,
    StFinWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [EBITS-1:0] exp_q, exp_d;
  logic [8:0]       len_q, len_d;
  logic [1:0]       op_q, op_d;
  logic [DBITS-1:0] result_q, result_d;
  logic [DBITS-1:0] mem_q [4];
  logic [DBITS-1:0] mem_d [4];

  logic drain_last;
  logic cur_bit;
  logic in_wait;
  logic wr_ok;

  assign drain_last = (cnt_q == DrainLast);
  assign cur_bit    = exp_q[idx_q];
  assign in_wait    = (state_q == StSqWait) || (state_q == StMulWait) ||
                      (state_q == StFinWait);
  assign wr_ok      = in_wait && mp_wr_en && (32'(mp_wr_addr) < 32'd4);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StDrain;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDrain:    if (drain_last) state_d = StIdle;
      StIdle:     if (go) state_d = StLoad;
      StLoad:     state_d = (len_q == 9'd0) ? StFinIssue : StSqIssue;
      StSqIssue:  state_d = StSqWait;
      StMulIssue: state_d = StMulWait;
      StFinIssue: state_d = StFinWait;
      StSqWait: begin
        if (mp_stop) begin
          if (cur_bit) begin
            state_d = StMulIssue;
          end else begin
            state_d = (idx_q == '0) ? StFinIssue : StSqIssue;
          end
        end
      end
      StMulWait: begin
        if (mp_stop) state_d = (idx_q == '0) ? StFinIssue : StSqIssue;
      end
      StFinWait:  if (mp_stop) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StDrain;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    mp_start = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      StSqIssue, StMulIssue, StFinIssue: mp_start = 1'b1;
      default: ;
    endcase
  end

  assign mp_op_code = op_q;
  assign result     = result_q;
  assign mp_count   = (LOG_BITLEN + 1)'(MP_COUNT);
  assign mp_rd_data = (32'(mp_rd_addr) < 32'd4) ? mem_q[mp_rd_addr[1:0]] : '0;

  // Datapath next-state: counters, latched operands, memory, result
  always_comb begin
    cnt_d    = '0;
    idx_d    = idx_q;
    exp_d    = exp_q;
    len_d    = len_q;
    op_d     = op_q;
    result_d = result_q;
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (state_q == StDrain) cnt_d = cnt_q + 1'b1;

    if (state_q == StIdle && go) begin
      exp_d = exp;
      len_d = exp_len;
    end

    if (state_q == StLoad) begin
      mem_d[0] = x_bar_init;
      mem_d[2] = m_bar_init;
      if (len_q != 9'd0) idx_d = IdxW'(len_q - 9'd1);
    end

    // Index steps after a multiply, or after a square whose bit is 0
    if (mp_stop && idx_q != '0 &&
        ((state_q == StSqWait && !cur_bit) || state_q == StMulWait)) begin
      idx_d = idx_q - 1'b1;
    end

    if (wr_ok) mem_d[mp_wr_addr[1:0]] = mp_wr_data;

    // Memory is current once stop is seen, so word 0 is final here
    if (state_q == StFinWait && mp_stop) result_d = mem_q[0];

    unique case (state_d)
      StSqIssue:  op_d = OpXX;
      StMulIssue: op_d = OpXM;
      StFinIssue: op_d = OpX1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      exp_q    <= '0;
      len_q    <= '0;
      op_q     <= OpXX;
      result_q <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      len_q    <= len_d;
      op_q     <= op_d;
      result_q <= result_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a stub product engine that stops
// five cycles after each start and writes 0x10+k to word 0.
module tb_mod_exp_ctrl;

  localparam int unsigned ABITS      = 8;
  localparam int unsigned DBITS      = 256;
  localparam int unsigned LOG_BITLEN = 8;
  localparam int unsigned MP_COUNT   = 256;
  localparam int unsigned EBITS      = 256;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                go = 1'b0;
  logic [EBITS-1:0]    e_in = '0;
  logic [8:0]          e_len = '0;
  logic [DBITS-1:0]    x_bar = '0;
  logic [DBITS-1:0]    m_bar = '0;
  logic                busy;
  logic                done;
  logic [DBITS-1:0]    result;
  logic                mp_start;
  logic [1:0]          mp_op_code;
  logic [LOG_BITLEN:0] mp_count;
  logic [ABITS-1:0]    rd_addr = '0;
  logic [DBITS-1:0]    rd_data;

  // Stub engine
  logic                stop_s = 1'b0;
  logic                st_wr = 1'b0;
  logic                run = 1'b0;
  int                  scnt = 0;
  logic [7:0]          k = '0;

  // Bench-injected stray writes
  logic                tb_wr = 1'b0;
  logic [ABITS-1:0]    tb_addr = '0;
  logic [DBITS-1:0]    tb_data = '0;

  logic                wr_en;
  logic [ABITS-1:0]    wr_addr;
  logic [DBITS-1:0]    wr_data;

  assign wr_en   = st_wr | tb_wr;
  assign wr_addr = tb_wr ? tb_addr : '0;
  assign wr_data = tb_wr ? tb_data : DBITS'(8'h10 + k);

  int checks = 0;
  int errors = 0;
  int op_log [64];
  int n_ops = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(
    .ABITS(ABITS), .DBITS(DBITS), .LOG_BITLEN(LOG_BITLEN),
    .MP_COUNT(MP_COUNT), .EBITS(EBITS)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .exp(e_in), .exp_len(e_len),
    .x_bar_init(x_bar), .m_bar_init(m_bar), .busy(busy), .done(done),
    .result(result), .mp_start(mp_start), .mp_op_code(mp_op_code),
    .mp_count(mp_count), .mp_stop(stop_s), .mp_rd_addr(rd_addr),
    .mp_rd_data(rd_data), .mp_wr_addr(wr_addr), .mp_wr_data(wr_data),
    .mp_wr_en(wr_en)
  );

  always @(posedge clk) begin
    if (mp_start) begin
      run    <= 1'b1;
      scnt   <= 1;
      stop_s <= 1'b0;
      st_wr  <= 1'b0;
    end else if (run) begin
      if (scnt == 4) begin
        st_wr <= 1'b1;
        scnt  <= 5;
      end else if (scnt == 5) begin
        st_wr  <= 1'b0;
        stop_s <= 1'b1;
        run    <= 1'b0;
        k      <= k + 8'd1;
      end else begin
        scnt <= scnt + 1;
      end
    end
    if (go && !busy && !done) k <= '0;
  end

  always @(posedge clk) begin
    if (mp_start && n_ops < 64) begin
      op_log[n_ops] <= int'(mp_op_code);
      n_ops <= n_ops + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [DBITS-1:0] obs,
                       input logic [DBITS-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_go(input logic [EBITS-1:0] e, input logic [8:0] len,
                          input logic [DBITS-1:0] x, input logic [DBITS-1:0] m);
    e_in  = e;
    e_len = len;
    x_bar = x;
    m_bar = m;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
  endtask

  task automatic wait_done(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int cnt;
    int base;
    bit ok;
    int exp_ops [8];
    exp_ops = '{0, 1, 0, 0, 1, 0, 1, 2};

    // Reset values, with go held high throughout reset and drain
    go = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", DBITS'(busy), 1);
    check("rst_done", DBITS'(done), 0);
    check("rst_start", DBITS'(mp_start), 0);
    check("rst_op", DBITS'(mp_op_code), 0);
    check("rst_result", result, 0);
    check("mp_count", DBITS'(mp_count), MP_COUNT);
    rd_addr = 8'd0;
    #1 check("rst_word0", rd_data, 0);

    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000 && busy; i++) begin
      cnt++;
      @(negedge clk);
    end
    go = 1'b0;
    check("drain_cycles", DBITS'(cnt), MP_COUNT + 4);
    check("drain_no_start", DBITS'(n_ops), 0);
    @(negedge clk);
    check("drain_go_ignored", DBITS'(busy), 0);

    // exp=0xB, exp_len=4
    base = n_ops;
    start_go(256'hB, 9'd4, 256'h1, 256'h2);
    check("run_busy", DBITS'(busy), 1);
    wait_done("run", ok);
    if (ok) begin
      check("run_result", result, 256'h17);
      check("run_nops", DBITS'(n_ops - base), 8);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("run_op%0d", i), DBITS'(op_log[base + i]), DBITS'(exp_ops[i]));
      end
      @(negedge clk);
      check("run_idle_busy", DBITS'(busy), 0);
      check("run_done_pulse", DBITS'(done), 0);
    end

    // Stray write in IDLE is dropped
    tb_wr = 1'b1; tb_addr = 8'd0; tb_data = 256'hFF;
    @(negedge clk);
    tb_wr = 1'b0;
    rd_addr = 8'd0;
    #1 check("idle_stray_wr", rd_data, 256'h17);

    // exp_len=0: single OPX1
    base = n_ops;
    start_go(256'h0, 9'd0, 256'h5, 256'hA5);
    @(negedge clk);
    check("len0_start", DBITS'(mp_start), 1);
    check("len0_op", DBITS'(mp_op_code), 2);
    rd_addr = 8'd0;
    #1 check("len0_rd0", rd_data, 256'h5);
    rd_addr = 8'd2;
    #1 check("rd_async2", rd_data, 256'hA5);
    rd_addr = 8'd7;
    #1 check("rd_oob", rd_data, 0);
    tb_wr = 1'b1; tb_addr = 8'd0; tb_data = 256'hFF;
    @(negedge clk);
    tb_wr = 1'b0;
    rd_addr = 8'd0;
    #1 check("issue_stray_wr", rd_data, 256'h5);
    wait_done("len0", ok);
    if (ok) begin
      check("len0_result", result, 256'h10);
      check("len0_nops", DBITS'(n_ops - base), 1);
      check("len0_opx1", DBITS'(op_log[base]), 2);
    end
    @(negedge clk);

    // Reset during MUL_WAIT
    start_go(256'h1, 9'd1, 256'h3, 256'h4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mp_start && mp_op_code == 2'd1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("mul_issue_timeout", 1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_busy", DBITS'(busy), 1);
    check("mrst_done", DBITS'(done), 0);
    check("mrst_start", DBITS'(mp_start), 0);
    check("mrst_result", result, 0);
    rd_addr = 8'd0;
    #1 check("mrst_word0", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check("mrst_drained", DBITS'(busy), 0);

    base = n_ops;
    start_go(256'h1, 9'd1, 256'h3, 256'h4);
    wait_done("after_rst", ok);
    if (ok) begin
      check("after_rst_result", result, 256'h12);
      check("after_rst_nops", DBITS'(n_ops - base), 3);
    end
    @(negedge clk);
    check("done_count", DBITS'(done_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
